// File: rtl/impix_pkg.sv
// impix_pkg -- shared types and constants for the pixelate controller.
//   state_e      : controller FSM states
//   CSR_*        : CSR word offsets on the Avalon-MM slave
//   ACC_W/PIX_W  : block accumulator width / pixel width
//   blk_side()   : block edge length B = 2^log2_blk
package impix_pkg;

   localparam int ACC_W = 16;
   localparam int PIX_W = 8;

   localparam logic [2:0] CSR_CTRL   = 3'd0;
   localparam logic [2:0] CSR_STATUS = 3'd1;
   localparam logic [2:0] CSR_SRC    = 3'd2;
   localparam logic [2:0] CSR_DST    = 3'd3;
   localparam logic [2:0] CSR_WIDTH  = 3'd4;
   localparam logic [2:0] CSR_HEIGHT = 3'd5;
   localparam logic [2:0] CSR_LOG2   = 3'd6;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_CHECK,
      ST_RD_REQ,
      ST_RD_WAIT,
      ST_AVG,
      ST_WR_REQ,
      ST_NEXT_BLK
   } state_e;

   // Only meaningful for log2_blk 1..4 (the legal range); larger values alias.
   function automatic logic [4:0] blk_side(input logic [2:0] l2);
      return 5'd1 << l2;
   endfunction

endpackage

// File: rtl/impix_addr_gen.sv
// impix_addr_gen -- block/pixel walker and byte-address generator.
//   clk, rst_n      : clock, async active-low reset
//   clear           : zero all counters (start of image)
//   pix_step        : advance (r,c) row-major inside the block, wrapping to 0
//   blk_step        : advance (bx,by) row-major over blocks, zero (r,c)
//   sel_dst         : address relative to dst_base instead of src_base
//   width/height    : image size in pixels, log2_blk: block edge exponent
//   addr            : base + (by*B + r)*width + bx*B + c
//   last_pixel      : (r,c) is the final pixel of the block
//   last_block      : (bx,by) is the final block of the image
module impix_addr_gen
   import impix_pkg::*;
#(
   parameter int ADDR_W = 32,
   parameter int DIM_W  = 12
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              clear,
   input  logic              pix_step,
   input  logic              blk_step,
   input  logic              sel_dst,
   input  logic [DIM_W-1:0]  width,
   input  logic [DIM_W-1:0]  height,
   input  logic [2:0]        log2_blk,
   input  logic [ADDR_W-1:0] src_base,
   input  logic [ADDR_W-1:0] dst_base,
   output logic [ADDR_W-1:0] addr,
   output logic              last_pixel,
   output logic              last_block
);

   logic [3:0]        r, c;
   logic [DIM_W-1:0]  bx, by;
   logic [4:0]        side;
   logic [3:0]        blk_max;
   logic [DIM_W-1:0]  nbx_max, nby_max;
   logic [ADDR_W-1:0] row, col;

   // B=16 gives 16-1 = 15 in 4 bits, which is exactly the last index.
   assign side    = blk_side(log2_blk);
   assign blk_max = 4'(side - 5'd1);
   assign nbx_max = (width  >> log2_blk) - DIM_W'(1);
   assign nby_max = (height >> log2_blk) - DIM_W'(1);

   assign last_pixel = (r == blk_max) && (c == blk_max);
   assign last_block = (bx == nbx_max) && (by == nby_max);

   assign row  = (ADDR_W'(by) << log2_blk) + ADDR_W'(r);
   assign col  = (ADDR_W'(bx) << log2_blk) + ADDR_W'(c);
   assign addr = (sel_dst ? dst_base : src_base) + row * ADDR_W'(width) + col;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r  <= '0;
         c  <= '0;
         bx <= '0;
         by <= '0;
      end else if (clear) begin
         r  <= '0;
         c  <= '0;
         bx <= '0;
         by <= '0;
      end else if (blk_step) begin
         r <= '0;
         c <= '0;
         if (bx == nbx_max) begin
            bx <= '0;
            by <= by + DIM_W'(1);
         end else begin
            bx <= bx + DIM_W'(1);
         end
      end else if (pix_step) begin
         // Wrapping after the last pixel rearms (r,c) for the write pass.
         if (c == blk_max) begin
            c <= '0;
            r <= (r == blk_max) ? 4'd0 : r + 4'd1;
         end else begin
            c <= c + 4'd1;
         end
      end
   end

endmodule

// File: rtl/impix_pixelate_ctrl.sv
// impix_pixelate_ctrl -- block-average (pixelate) engine with Avalon-MM CSR
// slave and pixel master. Each BxB block of the source image is read, its
// mean is computed and written to every pixel of the same block in the
// destination image.
//   clk_clk, reset_reset_n : clock, async active-low reset
//   avs_*                  : CSR slave (CTRL, STATUS, SRC, DST, WIDTH, HEIGHT, LOG2)
//   avm_*                  : byte-wide pixel master, one read outstanding max
//   irq                    : DONE & IRQ_EN, registered
module impix_pixelate_ctrl
   import impix_pkg::*;
#(
   parameter int ADDR_W = 32,
   parameter int DIM_W  = 12
) (
   input  logic              clk_clk,
   input  logic              reset_reset_n,
   input  logic [2:0]        avs_address,
   input  logic              avs_write,
   input  logic [31:0]       avs_writedata,
   input  logic              avs_read,
   output logic [31:0]       avs_readdata,
   output logic [ADDR_W-1:0] avm_address,
   output logic              avm_read,
   output logic              avm_write,
   output logic [7:0]        avm_writedata,
   input  logic [7:0]        avm_readdata,
   input  logic              avm_readdatavalid,
   input  logic              avm_waitrequest,
   output logic              irq
);

   state_e state, state_nxt;

   logic              irq_en, done, err;
   logic [ADDR_W-1:0] src_base, dst_base;
   logic [DIM_W-1:0]  width_r, height_r;
   logic [2:0]        log2_blk;
   logic [ACC_W-1:0]  acc;
   logic [PIX_W-1:0]  avg;

   logic busy, start, cfg_bad;
   logic [DIM_W-1:0] blk_mask;
   logic [31:0] rd_mux;

   logic sel_dst, pix_step, blk_step, cnt_clr, acc_clr, acc_add, avg_ld;
   logic set_done, set_err, last_pixel, last_block;

   assign busy  = (state != ST_IDLE);
   assign start = avs_write && (avs_address == CSR_CTRL) && avs_writedata[0] && !busy;

   assign blk_mask = (DIM_W'(1) << log2_blk) - DIM_W'(1);
   assign cfg_bad  = (log2_blk < 3'd1) || (log2_blk > 3'd4) ||
                     (width_r == '0) || (height_r == '0) ||
                     ((width_r & blk_mask) != '0) || ((height_r & blk_mask) != '0);

   impix_addr_gen #(.ADDR_W(ADDR_W), .DIM_W(DIM_W)) u_addr_gen (
      .clk        (clk_clk),
      .rst_n      (reset_reset_n),
      .clear      (cnt_clr),
      .pix_step   (pix_step),
      .blk_step   (blk_step),
      .sel_dst    (sel_dst),
      .width      (width_r),
      .height     (height_r),
      .log2_blk   (log2_blk),
      .src_base   (src_base),
      .dst_base   (dst_base),
      .addr       (avm_address),
      .last_pixel (last_pixel),
      .last_block (last_block)
   );

   // FSM state register
   always_ff @(posedge clk_clk or negedge reset_reset_n) begin
      if (!reset_reset_n) state <= ST_IDLE;
      else                state <= state_nxt;
   end

   // FSM next state
   always_comb begin
      state_nxt = state;
      case (state)
         ST_IDLE:     if (start) state_nxt = ST_CHECK;
         ST_CHECK:    state_nxt = cfg_bad ? ST_IDLE : ST_RD_REQ;
         ST_RD_REQ:   if (!avm_waitrequest) state_nxt = ST_RD_WAIT;
         ST_RD_WAIT:  if (avm_readdatavalid) state_nxt = last_pixel ? ST_AVG : ST_RD_REQ;
         ST_AVG:      state_nxt = ST_WR_REQ;
         ST_WR_REQ:   if (!avm_waitrequest && last_pixel) state_nxt = ST_NEXT_BLK;
         ST_NEXT_BLK: state_nxt = last_block ? ST_IDLE : ST_RD_REQ;
         default:     state_nxt = ST_IDLE;
      endcase
   end

   // FSM outputs; read and write strobes come from distinct states so they
   // can never overlap.
   always_comb begin
      avm_read = 1'b0;
      avm_write = 1'b0;
      sel_dst  = 1'b0;
      pix_step = 1'b0;
      blk_step = 1'b0;
      cnt_clr  = 1'b0;
      acc_clr  = 1'b0;
      acc_add  = 1'b0;
      avg_ld   = 1'b0;
      set_done = 1'b0;
      set_err  = 1'b0;
      case (state)
         ST_CHECK: begin
            if (cfg_bad) set_err = 1'b1;
            else begin
               cnt_clr = 1'b1;
               acc_clr = 1'b1;
            end
         end
         ST_RD_REQ:  avm_read = 1'b1;
         ST_RD_WAIT: begin
            acc_add  = avm_readdatavalid;
            pix_step = avm_readdatavalid;
         end
         ST_AVG:     avg_ld = 1'b1;
         ST_WR_REQ: begin
            avm_write = 1'b1;
            sel_dst   = 1'b1;
            pix_step  = !avm_waitrequest;
         end
         ST_NEXT_BLK: begin
            if (last_block) set_done = 1'b1;
            else begin
               blk_step = 1'b1;
               acc_clr  = 1'b1;
            end
         end
         default: ;
      endcase
   end

   assign avm_writedata = avg;

   // 256 * 255 = 65280 fits the 16-bit accumulator without overflow.
   always_ff @(posedge clk_clk or negedge reset_reset_n) begin
      if (!reset_reset_n) begin
         acc <= '0;
         avg <= '0;
      end else begin
         if (acc_clr)      acc <= '0;
         else if (acc_add) acc <= acc + ACC_W'(avm_readdata);
         if (avg_ld)       avg <= PIX_W'(acc >> {log2_blk, 1'b0});
      end
   end

   always_comb begin
      rd_mux = '0;
      case (avs_address)
         CSR_CTRL:   rd_mux = {30'd0, irq_en, 1'b0};
         CSR_STATUS: rd_mux = {29'd0, err, done, busy};
         CSR_SRC:    rd_mux = 32'(src_base);
         CSR_DST:    rd_mux = 32'(dst_base);
         CSR_WIDTH:  rd_mux = 32'(width_r);
         CSR_HEIGHT: rd_mux = 32'(height_r);
         CSR_LOG2:   rd_mux = {29'd0, log2_blk};
         default:    rd_mux = '0;
      endcase
   end

   // CSRs: geometry/base registers are frozen while busy; sticky flags set
   // by the FSM take priority over a same-cycle W1C.
   always_ff @(posedge clk_clk or negedge reset_reset_n) begin
      if (!reset_reset_n) begin
         irq_en       <= 1'b0;
         done         <= 1'b0;
         err          <= 1'b0;
         src_base     <= '0;
         dst_base     <= '0;
         width_r      <= '0;
         height_r     <= '0;
         log2_blk     <= '0;
         irq          <= 1'b0;
         avs_readdata <= '0;
      end else begin
         if (avs_write && avs_address == CSR_CTRL) irq_en <= avs_writedata[1];
         if (avs_write && !busy) begin
            case (avs_address)
               CSR_SRC:    src_base <= ADDR_W'(avs_writedata);
               CSR_DST:    dst_base <= ADDR_W'(avs_writedata);
               CSR_WIDTH:  width_r  <= avs_writedata[DIM_W-1:0];
               CSR_HEIGHT: height_r <= avs_writedata[DIM_W-1:0];
               CSR_LOG2:   log2_blk <= avs_writedata[2:0];
               default: ;
            endcase
         end
         if (set_done) done <= 1'b1;
         else if (avs_write && avs_address == CSR_STATUS && avs_writedata[1]) done <= 1'b0;
         if (set_err) err <= 1'b1;
         else if (avs_write && avs_address == CSR_STATUS && avs_writedata[2]) err <= 1'b0;
         irq <= done & irq_en;
         if (avs_read) avs_readdata <= rd_mux;
      end
   end

endmodule

// File: tb/tb_impix_pixelate_ctrl.sv
// Scoreboarded bench for impix_pixelate_ctrl: a byte memory model serves the
// master port; expected destination writes are queued when a run is started
// and popped/compared by the memory model whenever the DUT's write is taken.
module tb_impix_pixelate_ctrl;

   typedef struct packed {
      logic [31:0] addr;
      logic [7:0]  data;
   } exp_t;

   logic        clk = 0;
   logic        rst_n = 0;
   logic [2:0]  avs_address = '0;
   logic        avs_write = 0;
   logic [31:0] avs_writedata = '0;
   logic        avs_read = 0;
   logic [31:0] avs_readdata;
   logic [31:0] avm_address;
   logic        avm_read, avm_write;
   logic [7:0]  avm_writedata;
   logic [7:0]  avm_readdata = '0;
   logic        avm_readdatavalid = 0;
   logic        avm_waitrequest = 0;
   logic        irq;

   impix_pixelate_ctrl #(.ADDR_W(32), .DIM_W(12)) dut (
      .clk_clk           (clk),
      .reset_reset_n     (rst_n),
      .avs_address       (avs_address),
      .avs_write         (avs_write),
      .avs_writedata     (avs_writedata),
      .avs_read          (avs_read),
      .avs_readdata      (avs_readdata),
      .avm_address       (avm_address),
      .avm_read          (avm_read),
      .avm_write         (avm_write),
      .avm_writedata     (avm_writedata),
      .avm_readdata      (avm_readdata),
      .avm_readdatavalid (avm_readdatavalid),
      .avm_waitrequest   (avm_waitrequest),
      .irq               (irq)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int failures = 0;

   logic [7:0]  mem [0:4095];
   exp_t        exp_q[$];
   int          avg_tab [0:15];
   bit          stall_en = 0;
   bit          pending = 0;
   int          lat_cnt = 0;
   logic [31:0] paddr = '0;
   int          rd_cnt = 0, wr_cnt = 0, first_wr_rd = -1;
   bit          both_seen = 0, dbl_out = 0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
      checks++;
      if (act !== req) begin
         failures++;
         $display("FAIL %s actual=%0h required=%0h", name, act, req);
      end
   endtask

   // Memory model + write monitor. Runs mid-cycle: inputs set here are seen
   // at the next posedge, so a request seen now with waitrequest=0 is taken.
   always @(negedge clk) begin
      if (!rst_n) begin
         pending = 0;
         avm_readdatavalid = 0;
         avm_waitrequest = 0;
      end else begin
         bit ws;
         exp_t e;
         avm_readdatavalid = 0;
         if (pending) begin
            if (lat_cnt <= 1) begin
               avm_readdatavalid = 1;
               avm_readdata = mem[paddr[11:0]];
               pending = 0;
            end else lat_cnt--;
         end
         if (avm_read && avm_write) both_seen = 1;
         ws = stall_en ? ($urandom_range(0, 1) == 1) : 1'b0;
         avm_waitrequest = ws;
         if (avm_read && !ws) begin
            if (pending) dbl_out = 1;
            pending = 1;
            paddr = avm_address;
            lat_cnt = stall_en ? int'($urandom_range(1, 5)) : 1;
            rd_cnt++;
         end
         if (avm_write && !ws) begin
            if (wr_cnt == 0) first_wr_rd = rd_cnt;
            wr_cnt++;
            mem[avm_address[11:0]] = avm_writedata;
            if (exp_q.size() == 0) begin
               checks++;
               failures++;
               $display("FAIL unexpected_write actual=%0h:%0h required=none", avm_address, avm_writedata);
            end else begin
               e = exp_q.pop_front();
               check("wr_addr", 64'(avm_address), 64'(e.addr));
               check("wr_data", 64'(avm_writedata), 64'(e.data));
            end
         end
      end
   end

   task automatic csr_write(input logic [2:0] a, input logic [31:0] d);
      @(negedge clk);
      avs_address = a; avs_writedata = d; avs_write = 1;
      @(negedge clk);
      avs_write = 0;
   endtask

   task automatic csr_read(input logic [2:0] a, output logic [31:0] d);
      @(negedge clk);
      avs_address = a; avs_read = 1;
      @(negedge clk);
      avs_read = 0;
      d = avs_readdata;
   endtask

   task automatic program_img(input logic [31:0] src, dst, input int w, h, l2);
      csr_write(3'd2, src);
      csr_write(3'd3, dst);
      csr_write(3'd4, 32'(w));
      csr_write(3'd5, 32'(h));
      csr_write(3'd6, 32'(l2));
   endtask

   task automatic clr_stats();
      rd_cnt = 0; wr_cnt = 0; first_wr_rd = -1; both_seen = 0; dbl_out = 0;
   endtask

   // Queue every destination write: row-major blocks, row-major pixels,
   // block k carrying avg_tab[k].
   task automatic push_exp(input int w, h, l2, input logic [31:0] dst);
      int b, k;
      b = 1 << l2;
      k = 0;
      for (int by = 0; by < h / b; by++)
         for (int bx = 0; bx < w / b; bx++) begin
            for (int r = 0; r < b; r++)
               for (int c = 0; c < b; c++)
                  exp_q.push_back('{addr: dst + 32'((by * b + r) * w + bx * b + c),
                                    data: 8'(avg_tab[k])});
            k++;
         end
   endtask

   task automatic wait_idle(input string name, input int max_polls);
      logic [31:0] s;
      int n;
      n = 0;
      do begin
         csr_read(3'd1, s);
         n++;
      end while (s[0] && n < max_polls);
      check(name, 64'(s[0]), 64'd0);
   endtask

   task automatic set_avg4(input int a0, a1, a2, a3);
      avg_tab[0] = a0; avg_tab[1] = a1; avg_tab[2] = a2; avg_tab[3] = a3;
   endtask

   initial begin
      logic [31:0] rd;
      int n;
      for (int i = 0; i < 4096; i++) mem[i] = 8'hEE;
      for (int i = 0; i < 16; i++) mem[16'h100 + i] = 8'(i);
      for (int i = 0; i < 256; i++) mem[16'h400 + i] = 8'hFF;

      // Reset state
      repeat (3) @(negedge clk);
      check("rst_avm_read", 64'(avm_read), 0);
      check("rst_avm_write", 64'(avm_write), 0);
      check("rst_irq", 64'(irq), 0);
      check("rst_readdata", 64'(avs_readdata), 0);
      rst_n = 1;
      csr_read(3'd1, rd); check("rst_status", 64'(rd), 0);
      csr_read(3'd6, rd); check("rst_log2", 64'(rd), 0);
      csr_read(3'd4, rd); check("rst_width", 64'(rd), 0);

      // 4x4, B=2, pixels 0..15 -> 2,4,10,12 with irq enabled
      program_img(32'h100, 32'h200, 4, 4, 1);
      csr_read(3'd2, rd); check("src_readback", 64'(rd), 64'h100);
      csr_read(3'd7, rd); check("unmapped_read", 64'(rd), 0);
      clr_stats();
      set_avg4(2, 4, 10, 12);
      push_exp(4, 4, 1, 32'h200);
      csr_write(3'd0, 32'h3);
      wait_idle("s1_busy_timeout", 200);
      csr_read(3'd1, rd); check("s1_status_done", 64'(rd), 64'h2);
      check("s1_irq", 64'(irq), 1);
      check("s1_reads", 64'(rd_cnt), 16);
      check("s1_writes", 64'(wr_cnt), 16);
      check("s1_q_empty", 64'(exp_q.size()), 0);
      csr_write(3'd1, 32'h2);
      check("s1_irq_still_reg", 64'(irq), 1);
      @(negedge clk);
      check("s1_irq_w1c", 64'(irq), 0);
      csr_read(3'd1, rd); check("s1_status_clr", 64'(rd), 0);

      // 16x16, B=16, all 255, in place, irq disabled
      program_img(32'h400, 32'h400, 16, 16, 4);
      clr_stats();
      for (int i = 0; i < 16; i++) avg_tab[i] = 255;
      push_exp(16, 16, 4, 32'h400);
      csr_write(3'd0, 32'h1);
      wait_idle("s2_busy_timeout", 1000);
      csr_read(3'd1, rd); check("s2_status_done", 64'(rd), 64'h2);
      check("s2_irq_off", 64'(irq), 0);
      check("s2_reads", 64'(rd_cnt), 256);
      check("s2_writes", 64'(wr_cnt), 256);
      check("s2_reads_before_wr", 64'(first_wr_rd), 256);
      check("s2_q_empty", 64'(exp_q.size()), 0);
      csr_write(3'd1, 32'h2);

      // Same 4x4 image under random stalls and read latency
      stall_en = 1;
      program_img(32'h100, 32'h300, 4, 4, 1);
      clr_stats();
      set_avg4(2, 4, 10, 12);
      push_exp(4, 4, 1, 32'h300);
      csr_write(3'd0, 32'h1);
      wait_idle("s3_busy_timeout", 500);
      check("s3_reads", 64'(rd_cnt), 16);
      check("s3_writes", 64'(wr_cnt), 16);
      check("s3_q_empty", 64'(exp_q.size()), 0);
      check("s3_two_outstanding", 64'(dbl_out), 0);
      check("s3_rd_wr_overlap", 64'(both_seen), 0);
      csr_write(3'd1, 32'h2);

      // Illegal geometry: WIDTH=6 with B=4, then LOG2_BLK=5
      stall_en = 0;
      program_img(32'h100, 32'h700, 6, 4, 2);
      clr_stats();
      csr_write(3'd0, 32'h1);
      csr_read(3'd1, rd); check("s4_err_not_busy", 64'(rd), 64'h4);
      check("s4_no_traffic", 64'(rd_cnt + wr_cnt), 0);
      csr_write(3'd1, 32'h4);
      csr_read(3'd1, rd); check("s4_err_w1c", 64'(rd), 0);
      program_img(32'h100, 32'h700, 4, 4, 5);
      csr_write(3'd0, 32'h1);
      csr_read(3'd1, rd); check("s4_log2_err", 64'(rd), 64'h4);
      check("s4_log2_no_traffic", 64'(rd_cnt + wr_cnt), 0);
      csr_write(3'd1, 32'h4);

      // START and WIDTH write while busy are ignored
      stall_en = 1;
      program_img(32'h100, 32'h500, 4, 4, 1);
      clr_stats();
      set_avg4(2, 4, 10, 12);
      push_exp(4, 4, 1, 32'h500);
      csr_write(3'd0, 32'h1);
      csr_write(3'd4, 32'd8);
      csr_write(3'd0, 32'h1);
      wait_idle("s5_busy_timeout", 500);
      repeat (10) @(negedge clk);
      csr_read(3'd1, rd); check("s5_single_run", 64'(rd), 64'h2);
      csr_read(3'd4, rd); check("s5_width_kept", 64'(rd), 4);
      check("s5_reads", 64'(rd_cnt), 16);
      check("s5_q_empty", 64'(exp_q.size()), 0);
      csr_write(3'd1, 32'h2);

      // Reset mid-block, then a clean run
      stall_en = 0;
      program_img(32'h100, 32'h600, 4, 4, 1);
      clr_stats();
      csr_write(3'd0, 32'h1);
      n = 0;
      while (!(rd_cnt >= 3 && avm_read) && n < 200) begin
         @(negedge clk);
         n++;
      end
      check("s6_reached_mid_block", 64'(n < 200), 1);
      #2 rst_n = 0;
      #1;
      check("s6_read_drop", 64'(avm_read), 0);
      check("s6_write_drop", 64'(avm_write), 0);
      exp_q.delete();
      repeat (3) @(negedge clk);
      rst_n = 1;
      csr_read(3'd1, rd); check("s6_status_after_rst", 64'(rd), 0);
      csr_read(3'd4, rd); check("s6_width_after_rst", 64'(rd), 0);
      program_img(32'h100, 32'h600, 4, 4, 1);
      clr_stats();
      set_avg4(2, 4, 10, 12);
      push_exp(4, 4, 1, 32'h600);
      csr_write(3'd0, 32'h3);
      wait_idle("s6_busy_timeout", 200);
      csr_read(3'd1, rd); check("s6_status_done", 64'(rd), 64'h2);
      check("s6_reads", 64'(rd_cnt), 16);
      check("s6_writes", 64'(wr_cnt), 16);
      check("s6_q_empty", 64'(exp_q.size()), 0);
      check("s6_irq", 64'(irq), 1);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
